cmp_pipe: RTL and testbench

//  Parametrised, pipelined, mode-selectable magnitude comparator. Successor to the fixed 4-bit signed-GE compare.

---
 rtl/cmp_pkg.sv | 20 ++
 rtl/cmp_flag.sv | 31 +++
 rtl/cmp_pipe.sv | 75 +++++++
 tb/tb_cmp_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// cmp_pkg: compare mode codes and subtractor flag bundle shared by the compare pipeline
package cmp_pkg;

    localparam logic [2:0] MODE_SGE = 3'd0;
    localparam logic [2:0] MODE_SGT = 3'd1;
    localparam logic [2:0] MODE_SLE = 3'd2;
    localparam logic [2:0] MODE_SLT = 3'd3;
    localparam logic [2:0] MODE_EQ  = 3'd4;
    localparam logic [2:0] MODE_NE  = 3'd5;
    localparam logic [2:0] MODE_UGE = 3'd6;
    localparam logic [2:0] MODE_ULT = 3'd7;

    typedef struct packed {
        logic n;
        logic v;
        logic z;
        logic c;
    } cmp_flags_t;

endpackage

// File: rtl/cmp_flag.sv
// cmp_flag: maps subtractor flags and a compare mode to the 1-bit compare result
module cmp_flag
    import cmp_pkg::*;
(
    input  cmp_flags_t flags,
    input  logic [2:0] mode,
    output logic       res
);

    logic sge;
    logic sgt;

    assign sge = ~(flags.n ^ flags.v);
    assign sgt = sge & ~flags.z;

    always_comb begin
        res = 1'b0;
        case (mode)
            MODE_SGE: res = sge;
            MODE_SGT: res = sgt;
            MODE_SLE: res = ~sgt;
            MODE_SLT: res = ~sge;
            MODE_EQ:  res = flags.z;
            MODE_NE:  res = ~flags.z;
            MODE_UGE: res = flags.c;
            MODE_ULT: res = ~flags.c;
            default:  res = 1'b0;
        endcase
    end

endmodule

// File: rtl/cmp_pipe.sv
// cmp_pipe: two-stage valid/ready magnitude comparator returning a flag and the flag-selected operand
module cmp_pipe
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [2:0]       MODE,
    input  logic             I_VALID,
    output logic             I_READY,
    output logic             O,
    output logic [WIDTH-1:0] O_SEL,
    output logic             O_VALID,
    input  logic             O_READY
);

    logic [WIDTH:0]   diff;
    cmp_flags_t       flags;
    logic             s1_valid;
    cmp_flags_t       s1_flags;
    logic [2:0]       s1_mode;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             res;
    logic             s2_adv;

    // A - B as A + ~B + 1; the carry out doubles as the unsigned no-borrow flag
    assign diff  = {1'b0, I0} + {1'b0, ~I1} + (WIDTH + 1)'(1);
    assign flags = '{
        n: diff[WIDTH-1],
        v: (I0[WIDTH-1] ^ I1[WIDTH-1]) & (diff[WIDTH-1] ^ I0[WIDTH-1]),
        z: diff[WIDTH-1:0] == '0,
        c: diff[WIDTH]
    };

    assign s2_adv  = ~O_VALID | O_READY;
    assign I_READY = ~s1_valid | s2_adv;

    cmp_flag u_flag (
        .flags (s1_flags),
        .mode  (s1_mode),
        .res   (res)
    );

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            s1_valid <= 1'b0;
            O_VALID  <= 1'b0;
            O        <= 1'b0;
            O_SEL    <= '0;
        end else begin
            if (I_READY)
                s1_valid <= I_VALID;
            if (s2_adv) begin
                O_VALID <= s1_valid;
                O       <= res;
                O_SEL   <= res ? s1_a : s1_b;
            end
        end
    end

    // Datapath is only qualified by s1_valid, so it needs no reset
    always_ff @(posedge CLK) begin
        if (I_READY) begin
            s1_flags <= flags;
            s1_mode  <= MODE;
            s1_a     <= I0;
            s1_b     <= I1;
        end
    end

endmodule

// File: tb/tb_cmp_pipe.sv
// tb_cmp_pipe: scoreboard bench for cmp_pipe at WIDTH=8 plus an exhaustive WIDTH=2 instance
module tb_cmp_pipe;

    typedef struct packed {
        logic       o;
        logic [7:0] sel;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] i0, i1;
    logic [2:0] mode;
    logic       iv, ordy;
    logic       i_ready, o, o_valid;
    logic [7:0] o_sel;

    logic [1:0] i0b, i1b;
    logic [2:0] modeb;
    logic       ivb;
    logic       ordyb = 1'b1;
    logic       i_readyb, ob, o_validb;
    logic [1:0] o_selb;

    exp_t q8[$];
    exp_t q2[$];
    exp_t e8, e2;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;
    bit   bp_en = 1'b0;
    int   bp_i = 0;
    int   run = 0;
    int   maxrun = 0;

    // Occupancy model of the two stages, used to predict I_READY and O_VALID
    logic m_s1 = 1'b0, m_ov = 1'b0;
    logic m_adv, m_ir;
    assign m_adv = !m_ov | ordy;
    assign m_ir  = !m_s1 | m_adv;

    always #5 clk = ~clk;

    cmp_pipe #(.WIDTH(8)) dut (
        .CLK(clk), .RESETN(rstn), .I0(i0), .I1(i1), .MODE(mode), .I_VALID(iv),
        .I_READY(i_ready), .O(o), .O_SEL(o_sel), .O_VALID(o_valid), .O_READY(ordy)
    );

    cmp_pipe #(.WIDTH(2)) dut2 (
        .CLK(clk), .RESETN(rstn), .I0(i0b), .I1(i1b), .MODE(modeb), .I_VALID(ivb),
        .I_READY(i_readyb), .O(ob), .O_SEL(o_selb), .O_VALID(o_validb), .O_READY(ordyb)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic ref_cmp(input int a, input int b, input logic [2:0] m, input int w);
        int sa, sb;
        sa = a[w-1] ? a - (1 << w) : a;
        sb = b[w-1] ? b - (1 << w) : b;
        case (m)
            3'd0: return sa >= sb;
            3'd1: return sa > sb;
            3'd2: return sa <= sb;
            3'd3: return sa < sb;
            3'd4: return a == b;
            3'd5: return a != b;
            3'd6: return a >= b;
            default: return a < b;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            m_s1 <= 1'b0;
            m_ov <= 1'b0;
        end else begin
            if (m_adv) m_ov <= m_s1;
            if (m_ir) m_s1 <= iv;
        end
    end

    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            ordy = (bp_i == 0);
            bp_i = (bp_i + 1) % 3;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rstn) begin
            chk("i_ready", i_ready, m_ir);
            chk("o_valid", o_valid, m_ov);
            run = o_valid ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
            if (o_valid && ordy) begin
                if (q8.size() == 0) fail_now("unexpected_output_w8");
                else begin
                    e8 = q8.pop_front();
                    chk("o", o, e8.o);
                    chk("o_sel", o_sel, e8.sel);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rstn && o_validb) begin
            if (q2.size() == 0) fail_now("unexpected_output_w2");
            else begin
                e2 = q2.pop_front();
                chk("w2_o", ob, e2.o);
                chk("w2_o_sel", o_selb, e2.sel[1:0]);
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] m,
                        input logic eo, input logic [7:0] es, input bit push);
        int n = 0;
        i0 = a; i1 = b; mode = m; iv = 1'b1;
        @(negedge clk);
        while (!i_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!i_ready) fail_now("accept_timeout");
        else if (push) q8.push_back('{o: eo, sel: es});
        @(posedge clk);
        #1;
        iv = 1'b0; i0 = 'x; i1 = 'x; mode = 'x;
    endtask

    task automatic check_latency(input string nm);
        chk({nm, "_after_accept_edge"}, o_valid, 1'b0);
        @(posedge clk);
        #1;
        chk({nm, "_after_second_edge"}, o_valid, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q8.size() != 0 || q2.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q8.size() != 0 || q2.size() != 0) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, b;
        logic [2:0] m;
        logic       r;
        rstn = 1'b0; iv = 1'b0; ivb = 1'b0; ordy = 1'b1;
        i0 = '0; i1 = '0; mode = '0; i0b = '0; i1b = '0; modeb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_o", o, 1'b0);
        chk("rst_o_sel", o_sel, 8'h00);
        chk("rst_i_ready", i_ready, 1'b1);
        rstn = 1'b1;
        chk_en = 1'b1;

        // Signed vs unsigned at the sign boundary
        send(8'h80, 8'h7F, 3'd0, 1'b0, 8'h7F, 1'b1);
        check_latency("lat_sge");
        send(8'h80, 8'h7F, 3'd6, 1'b1, 8'h80, 1'b1);
        drain();

        // Mode sweep on equal operands, back to back
        maxrun = 0;
        for (int k = 0; k < 8; k++)
            send(8'h05, 8'h05, 3'(k), ((8'b01010101 >> k) & 8'h01) != 0, 8'h05, 1'b1);
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("back_to_back_run", maxrun, 8);

        // Min/max selection
        send(8'hF0, 8'h03, 3'd3, 1'b1, 8'hF0, 1'b1);
        send(8'hF0, 8'h03, 3'd1, 1'b0, 8'h03, 1'b1);
        drain();

        // Backpressure with O_READY pattern 1,0,0
        bp_i = 0;
        bp_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            m = 3'($urandom_range(0, 7));
            r = ref_cmp(int'(a), int'(b), m, 8);
            send(a, b, m, r, r ? a : b, 1'b1);
        end
        drain();
        bp_en = 1'b0;
        @(posedge clk);
        #1;
        ordy = 1'b1;

        // Reset with two pairs held in the pipe
        ordy = 1'b0;
        send(8'h11, 8'h22, 3'd0, 1'b0, 8'h22, 1'b0);
        send(8'h33, 8'h44, 3'd0, 1'b0, 8'h44, 1'b0);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_o_valid", o_valid, 1'b0);
        chk("mid_rst_o_sel", o_sel, 8'h00);
        chk("mid_rst_i_ready", i_ready, 1'b1);
        rstn = 1'b1;
        ordy = 1'b1;
        send(8'h09, 8'h02, 3'd1, 1'b1, 8'h09, 1'b1);
        check_latency("lat_post_rst");
        drain();

        // WIDTH=2 exhaustive
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                for (int k = 0; k < 8; k++) begin
                    i0b = 2'(x); i1b = 2'(y); modeb = 3'(k); ivb = 1'b1;
                    @(negedge clk);
                    chk("w2_i_ready", i_readyb, 1'b1);
                    r = ref_cmp(x, y, 3'(k), 2);
                    q2.push_back('{o: r, sel: 8'(r ? x : y)});
                    @(posedge clk);
                    #1;
                end
        ivb = 1'b0;
        drain();

        chk("q8_empty", q8.size(), 0);
        chk("q2_empty", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
